mdu_div_iter: RTL and testbench
===============================

// Module: mdu_div_iter
// PURPOSE
//   Parametrised iterative restoring divider for the execute stage of the pipelined
//   datapath; successor to the fixed 32-bit divider. Adds: generic WIDTH, working annul
//   (exception flush), divide-by-zero flag, optional leading-zero early exit.
//   Result {remainder,quotient} feeds HI/LO; ready_o releases the datapath div stall.
// PARAMETERS
//   WIDTH       32  operand width in bits (>=4); result is 2*WIDTH
//   EARLY_EXIT  0   1 = skip leading zero bits of |dividend| (variable latency)
// PORTS
//   clk         in   1        clock, all state updates on rising edge
//   rst         in   1        synchronous, active-high reset
//   signed_i    in   1        1 = two's-complement divide, 0 = unsigned
//   opdata1_i   in   WIDTH    dividend, sampled only when start accepted
//   opdata2_i   in   WIDTH    divisor, sampled only when start accepted
//   start_i     in   1        request; level, held high by datapath while stalled
//   annul_i     in   1        abort current op (exception flush)
//   result_o    out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}
//   ready_o     out  1        result valid; high only in DONE
//   busy_o      out  1        high in DZERO/BUSY
//   dbz_o       out  1        divisor was zero for the result currently held
// BEHAVIOUR
//   Reset: state=IDLE; result_o=0, ready_o=0, busy_o=0, dbz_o=0; counter/remainder cleared.
//   States: IDLE, DZERO, BUSY, DONE.
//   IDLE : start_i&~annul_i -> latch operands; divisor==0 -> DZERO, else BUSY.
//   DZERO: one cycle; result_o<=0, dbz_o<=1 -> DONE.
//   BUSY : one quotient bit per cycle on |a|,|b| (magnitudes if signed_i, else raw);
//          partial remainder WIDTH+1 bits; subtract-and-restore. After N iterations -> DONE.
//          N=WIDTH if EARLY_EXIT=0; else N=WIDTH-lz(|a|), lz=leading zeros; |a|==0 uses N=1.
//   DONE : ready_o=1, result_o valid. Stays while start_i=1; start_i=0 -> IDLE.
//          No new op accepted from DONE (prevents re-issue while stall drops).
//   Latency: start sampled at edge t -> ready_o high from cycle t+N+1; DZERO: t+2.
//   Sign fix (signed_i=1): quotient negated iff sign(a)^sign(b); remainder takes sign(a).
//     Most-negative / -1 wraps: quotient=most-negative, remainder=0, no flag.
//   result_o/dbz_o hold last value until next op completes; updated only on DONE entry.
//   annul_i: from any state, next state IDLE, ready_o=0 next cycle, result_o unchanged;
//     annul_i has priority over start_i in the same cycle (no op accepted).
//   rst mid-op: same as reset, overrides annul/start.
//   Operand changes after acceptance ignored; signed_i also latched at acceptance.
// TESTING (WIDTH=32 unless noted)
//   unsigned 7/2, start at t -> ready_o at t+33, result_o={32'h1,32'h3}, dbz_o=0
//   signed -7/2 -> quotient 32'hFFFFFFFD, remainder 32'hFFFFFFFF; 32'h80000000/-1 -> {0,32'h80000000}
//   x/0 (unsigned and signed) -> ready_o at t+2, result_o=0, dbz_o=1; next valid op clears dbz_o
//   annul_i at t+10 of BUSY -> IDLE at t+11, ready_o never rises, result_o unchanged; new start ok
//   EARLY_EXIT=1, 7/2 -> ready_o at t+4, result {1,3}; 0/5 -> ready at t+2, result 0
//   hold start_i in DONE 5 cycles -> ready_o held, no restart; rst during BUSY -> all outputs 0 next cycle

Source files
------------

// File: rtl/mdu_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_div_iter
//  Description : Parametrised iterative restoring divider for the execute
//                stage. One quotient bit per cycle on operand magnitudes,
//                sign fix-up on completion, divide-by-zero flag, annul
//                (exception flush) and optional leading-zero early exit.
//                result_o = {remainder, quotient}.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module mdu_div_iter #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               dbz_o
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DZERO = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_nextState;

    logic [WIDTH-1:0]     r_quot;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]     r_divisor;   // |b|
    logic [WIDTH-1:0]     r_partRem;   // partial remainder, always < divisor
    logic [c_CNT_W-1:0]   r_count;     // iterations still to run
    logic                 r_negQuot;
    logic                 r_negRem;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_dbz;

    logic                 w_negA;
    logic                 w_negB;
    logic [WIDTH-1:0]     w_magA;
    logic [WIDTH-1:0]     w_magB;
    logic                 w_divZero;
    logic [WIDTH-1:0]     w_startQuot;
    logic [c_CNT_W-1:0]   w_iters;

    logic [WIDTH:0]       w_shifted;
    logic [WIDTH:0]       w_diff;
    logic                 w_qBit;
    logic [WIDTH-1:0]     w_newRem;
    logic [WIDTH-1:0]     w_newQuot;
    logic [WIDTH-1:0]     w_fixQuot;
    logic [WIDTH-1:0]     w_fixRem;
    logic                 w_lastIter;

    // Operand magnitudes; the most-negative value maps to itself, which is
    // the correct unsigned magnitude.
    assign w_negA    = signed_i & opdata1_i[WIDTH-1];
    assign w_negB    = signed_i & opdata2_i[WIDTH-1];
    assign w_magA    = w_negA ? (~opdata1_i + 1'b1) : opdata1_i;
    assign w_magB    = w_negB ? (~opdata2_i + 1'b1) : opdata2_i;
    assign w_divZero = (opdata2_i == '0);

    generate
        if (EARLY_EXIT) begin : g_earlyExit
            logic [c_CNT_W-1:0] w_lz;

            // Leading-zero count of |a|: highest set bit wins, zero gives WIDTH
            always_comb begin
                w_lz = c_CNT_W'(WIDTH);
                for (int i = 0; i < WIDTH; i++) begin
                    if (w_magA[i]) begin
                        w_lz = c_CNT_W'(WIDTH - 1 - i);
                    end
                end
            end

            // Pre-align the dividend so the first iteration sees its MSB;
            // a zero dividend still takes one iteration.
            assign w_startQuot = w_magA << w_lz;
            assign w_iters     = (w_magA == '0) ? c_CNT_W'(1)
                                                : (c_CNT_W'(WIDTH) - w_lz);
        end else begin : g_fixedLatency
            assign w_startQuot = w_magA;
            assign w_iters     = c_CNT_W'(WIDTH);
        end
    endgenerate

    // One restoring step: shift in next dividend bit, trial subtract.
    assign w_shifted  = {r_partRem, r_quot[WIDTH-1]};
    assign w_diff     = w_shifted - {1'b0, r_divisor};
    assign w_qBit     = ~w_diff[WIDTH];
    assign w_newRem   = w_qBit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    assign w_newQuot  = {r_quot[WIDTH-2:0], w_qBit};
    assign w_fixQuot  = r_negQuot ? (~w_newQuot + 1'b1) : w_newQuot;
    assign w_fixRem   = r_negRem ? (~w_newRem + 1'b1) : w_newRem;
    assign w_lastIter = (r_count == c_CNT_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; annul overrides every transition
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_nextState = w_divZero ? S_DZERO : S_BUSY;
                end
            end
            S_DZERO: w_nextState = S_DONE;
            S_BUSY: begin
                if (w_lastIter) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                if (!start_i) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
        if (annul_i) begin
            w_nextState = S_IDLE;
        end
    end

    // Datapath: latch on acceptance, iterate in BUSY, publish on DONE entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quot    <= '0;
            r_divisor <= '0;
            r_partRem <= '0;
            r_count   <= '0;
            r_negQuot <= 1'b0;
            r_negRem  <= 1'b0;
            r_result  <= '0;
            r_dbz     <= 1'b0;
        end else if (!annul_i) begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_quot    <= w_startQuot;
                        r_divisor <= w_magB;
                        r_partRem <= '0;
                        r_count   <= w_iters;
                        r_negQuot <= w_negA ^ w_negB;
                        r_negRem  <= w_negA;
                    end
                end
                S_DZERO: begin
                    r_result <= '0;
                    r_dbz    <= 1'b1;
                end
                S_BUSY: begin
                    r_partRem <= w_newRem;
                    r_quot    <= w_newQuot;
                    r_count   <= r_count - 1'b1;
                    if (w_lastIter) begin
                        r_result <= {w_fixRem, w_fixQuot};
                        r_dbz    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o = r_result;
    assign dbz_o    = r_dbz;
    assign ready_o  = (r_state == S_DONE);
    assign busy_o   = (r_state == S_DZERO) || (r_state == S_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_mdu_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_div_iter
//  Description : Self-checking bench for mdu_div_iter; a fixed-latency and
//                an early-exit instance share stimulus and are compared
//                against a plain-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_div_iter;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           signedIn;
    logic           start;
    logic           annul;
    logic [W-1:0]   opA;
    logic [W-1:0]   opB;

    logic [2*W-1:0] resFix;
    logic [2*W-1:0] resEarly;
    logic           readyFix;
    logic           readyEarly;
    logic           busyFix;
    logic           busyEarly;
    logic           dbzFix;
    logic           dbzEarly;

    int             errors = 0;
    int             checks = 0;
    logic [2*W-1:0] lastRes;
    logic           lastDbz;

    typedef struct {
        logic           sgn;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] expRes;
        logic           expDbz;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    mdu_div_iter #(.WIDTH(W), .EARLY_EXIT(1'b0)) dutFix (
        .clk(clk), .rst(rst), .signed_i(signedIn), .opdata1_i(opA), .opdata2_i(opB),
        .start_i(start), .annul_i(annul), .result_o(resFix), .ready_o(readyFix),
        .busy_o(busyFix), .dbz_o(dbzFix)
    );

    mdu_div_iter #(.WIDTH(W), .EARLY_EXIT(1'b1)) dutEarly (
        .clk(clk), .rst(rst), .signed_i(signedIn), .opdata1_i(opA), .opdata2_i(opB),
        .start_i(start), .annul_i(annul), .result_o(resEarly), .ready_o(readyEarly),
        .busy_o(busyEarly), .dbz_o(dbzEarly)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {dbz, remainder, quotient} from native 64-bit arithmetic
    function automatic logic [2*W:0] refModel(input logic sgn, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        longint x;
        longint y;
        longint q;
        longint r;
        if (b == '0) return {1'b1, {(2*W){1'b0}}};
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        q = x / y;
        r = x % y;
        return {1'b0, r[W-1:0], q[W-1:0]};
    endfunction

    // Number of significant bits in |a| (minimum 1): early-exit iteration count
    function automatic int sigBits(input logic sgn, input logic [W-1:0] a);
        longint m;
        int     n;
        m = (sgn && a[W-1]) ? -longint'($signed(a)) : longint'(a);
        n = 0;
        while (m != 0) begin
            n++;
            m = m >>> 1;
        end
        return (n == 0) ? 1 : n;
    endfunction

    task automatic runOp(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] expRes, input logic expDbz,
                         input int holdCycles, input string tag);
        int latF;
        int latE;
        int expF;
        int expE;
        latF = -1;
        latE = -1;
        expF = expDbz ? 1 : W;
        expE = expDbz ? 1 : sigBits(sgn, a);
        @(negedge clk);
        signedIn = sgn;
        opA      = a;
        opB      = b;
        start    = 1'b1;
        // j counts edges after the accepting edge
        for (int j = 0; j < 80 && (latF < 0 || latE < 0); j++) begin
            @(negedge clk);
            if (j == 0) begin
                opA      = ~a;
                opB      = $urandom;
                signedIn = ~sgn;
            end
            if (latF < 0 && readyFix)   latF = j;
            if (latE < 0 && readyEarly) latE = j;
        end
        check({tag, " lat_fix"},   64'(latF), 64'(expF));
        check({tag, " lat_early"}, 64'(latE), 64'(expE));
        check({tag, " res_fix"},   resFix,    expRes);
        check({tag, " res_early"}, resEarly,  expRes);
        check({tag, " dbz_fix"},   64'(dbzFix),   64'(expDbz));
        check({tag, " dbz_early"}, 64'(dbzEarly), 64'(expDbz));
        for (int k = 0; k < holdCycles; k++) begin
            @(negedge clk);
            check({tag, " hold_flags"}, 64'({readyFix, readyEarly, busyFix, busyEarly}),
                  64'(4'b1100));
            check({tag, " hold_res"}, resFix, expRes);
        end
        start = 1'b0;
        @(negedge clk);
        check({tag, " idle_flags"}, 64'({readyFix, readyEarly, busyFix, busyEarly}), 64'(0));
        lastRes = expRes;
        lastDbz = expDbz;
    endtask

    // Watchdog so a hung handshake still terminates the run
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic           sgn;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W:0]   m;
        logic           sawReady;

        vecs[0] = '{1'b0, 32'd7,         32'd2,         {32'd1,         32'd3},         1'b0};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,  32'd2,         {32'hFFFFFFFF,  32'hFFFFFFFD},  1'b0};
        vecs[2] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'd0,         32'h80000000},  1'b0};
        vecs[3] = '{1'b0, 32'd5,         32'd0,         64'd0,                          1'b1};
        vecs[4] = '{1'b0, 32'd100,       32'd7,         {32'd2,         32'd14},        1'b0};
        vecs[5] = '{1'b1, 32'hFFFFFFFB,  32'd0,         64'd0,                          1'b1};
        vecs[6] = '{1'b1, 32'd7,         32'hFFFFFFFE,  {32'd1,         32'hFFFFFFFD},  1'b0};
        vecs[7] = '{1'b0, 32'd0,         32'd5,         64'd0,                          1'b0};
        vecs[8] = '{1'b0, 32'hFFFFFFFF,  32'd1,         {32'd0,         32'hFFFFFFFF},  1'b0};
        vecs[9] = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  {32'h80000000,  32'd0},         1'b0};

        rst      = 1'b1;
        start    = 1'b0;
        annul    = 1'b0;
        signedIn = 1'b0;
        opA      = '0;
        opB      = '0;
        repeat (3) @(negedge clk);
        check("reset_res", {resFix ^ resEarly, 32'd0}, 64'd0);
        check("reset_res_fix", resFix, 64'd0);
        check("reset_flags", 64'({readyFix, readyEarly, busyFix, busyEarly, dbzFix, dbzEarly}),
              64'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            runOp(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].expRes, vecs[i].expDbz, 0,
                  $sformatf("vec%0d", i));
        end

        // start held in DONE: result stays, no re-issue
        runOp(1'b0, 32'd45, 32'd6, {32'd3, 32'd7}, 1'b0, 5, "hold");

        // annul mid-op (early instance is on its final iteration at that edge)
        @(negedge clk);
        signedIn = 1'b0;
        opA      = 32'd1000;
        opB      = 32'd3;
        start    = 1'b1;
        sawReady = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (readyFix || readyEarly) sawReady = 1'b1;
            if (j == 9) annul = 1'b1;
        end
        check("annul_no_ready", 64'(sawReady), 64'd0);
        @(negedge clk);
        check("annul_idle", 64'({readyFix, readyEarly, busyFix, busyEarly}), 64'd0);
        @(negedge clk);
        check("annul_priority", 64'({readyFix, readyEarly, busyFix, busyEarly}), 64'd0);
        check("annul_res_fix",   resFix,   lastRes);
        check("annul_res_early", resEarly, lastRes);
        check("annul_dbz", 64'({dbzFix, dbzEarly}), 64'({lastDbz, lastDbz}));
        annul = 1'b0;
        start = 1'b0;
        @(negedge clk);

        runOp(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 1'b0, 0, "after_annul");

        // reset during BUSY clears everything
        @(negedge clk);
        signedIn = 1'b1;
        opA      = 32'hFFFF0000;
        opB      = 32'd9;
        start    = 1'b1;
        repeat (5) @(negedge clk);
        check("busy_before_rst", 64'({busyFix, busyEarly}), 64'(2'b11));
        rst = 1'b1;
        @(negedge clk);
        check("rst_res_fix",   resFix,   64'd0);
        check("rst_res_early", resEarly, 64'd0);
        check("rst_flags", 64'({readyFix, readyEarly, busyFix, busyEarly, dbzFix, dbzEarly}),
              64'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        // randomized operations against the reference model
        for (int i = 0; i < 30; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            if (i % 3 == 0) a = a >> $urandom_range(0, 31);
            b   = $urandom;
            if (i % 2 == 0) b = b >> $urandom_range(0, 31);
            if (i % 7 == 3) b = '0;
            m = refModel(sgn, a, b);
            runOp(sgn, a, b, m[2*W-1:0], m[2*W], 0, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
